div_fu_ctrl: RTL and testbench
==============================

Name: div_fu_ctrl

Overview:
- Front-end controller for the iterative non-restoring divider (nrd_div) in the out-of-order core's divide functional unit.
- Accepts RV32M DIV/DIVU/REM/REMU ops with ROB tag from the divide reservation station.
- Resolves divide-by-zero and signed overflow locally without launching the divider; otherwise drives nrd_div's v/ready/yumi handshake, selects quotient or remainder, and broadcasts the result on the CDB under arbitration.
- Drops the operation on pipeline flush, draining the divider safely if it is in flight.

Parameters:
data_width_p, 32, operand/result width; fixed at 32 to match nrd_div's 5-bit iteration counter
tag_width_p, 6, ROB tag width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
issue_v_i  in  1  op valid from reservation station
issue_ready_o  out  1  block can accept an op
issue_op_i  in  2  div_op_e: DIV=0, DIVU=1, REM=2, REMU=3
issue_a_i  in  data_width_p  dividend
issue_b_i  in  data_width_p  divisor
issue_tag_i  in  tag_width_p  ROB tag
flush_i  in  1  kill the current op
div_v_o  out  1  launch request to nrd_div (drives v_i)
div_ready_i  in  1  nrd_div ready_o
div_signed_o  out  1  nrd_div signed_i
div_a_o  out  data_width_p  nrd_div a_i
div_b_o  out  data_width_p  nrd_div b_i
div_v_i  in  1  nrd_div v_o
div_quot_i  in  data_width_p  nrd_div div_o
div_rem_i  in  data_width_p  nrd_div rem_o
div_yumi_o  out  1  nrd_div yumi_i
cdb_req_o  out  1  CDB broadcast request
cdb_gnt_i  in  1  CDB grant
cdb_tag_o  out  tag_width_p  broadcast tag
cdb_data_o  out  data_width_p  broadcast result

Behaviour:
- Reset (reset_i low, asynchronous): state S_IDLE; all registers 0. Outputs: issue_ready_o=1, div_v_o=0, div_yumi_o=0, cdb_req_o=0, cdb_tag_o=0, cdb_data_o=0.
  - Reset mid-operation abandons the op.
  - nrd_div shares the reset net and also returns to idle.
- State S_IDLE:
  - issue_ready_o = ~flush_i.
  - Accept when issue_v_i & issue_ready_o.
  - On accept, register op, a, b and tag.
- Special cases (evaluated at accept):
  - Divisor 0: DIV/DIVU result = all-ones (0xFFFFFFFF); REM/REMU result = a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV or REM only): DIV result = 0x80000000; REM result = 0.
  - A special case loads the result register and moves to S_BCAST. cdb_req_o is high the cycle after accept (latency 1). The divider is not touched.
- Normal case: move to S_LAUNCH.
- S_LAUNCH:
  - div_v_o=1.
  - div_signed_o = op is DIV or REM.
  - div_a_o/div_b_o come from the registers and are stable while div_v_o is high.
  - Handshake occurs when div_ready_i=1; then go to S_WAIT.
  - flush_i before the handshake: go to S_IDLE; div_v_o deasserts the same cycle (combinational ~flush_i gating).
- S_WAIT:
  - On div_v_i=1: assert div_yumi_o that cycle, and capture div_quot_i (DIV/DIVU) or div_rem_i (REM/REMU) into the result register.
  - Go to S_BCAST next cycle.
  - flush_i in S_WAIT (or the same cycle as div_v_i without yumi already taken): go to S_DRAIN.
- S_DRAIN:
  - Wait for div_v_i, assert div_yumi_o, go to S_IDLE.
  - No CDB request. flush_i is ignored here.
- S_BCAST:
  - cdb_req_o=1; tag and data are held stable until the grant.
  - cdb_gnt_i=1: go to S_IDLE next cycle.
  - flush_i: go to S_IDLE and deassert cdb_req_o the same cycle (flush beats grant).
- Only one op is in flight. No issue is accepted outside S_IDLE.
- div_yumi_o is asserted only when div_v_i=1. div_v_o is asserted only in S_LAUNCH.

Decomposition:
- Package div_pkg holds:
  - div_op_e enum;
  - div_fu_state_e {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN, S_BCAST};
  - constants DIV_ZERO_QUOT (all-ones) and DIV_OVF_DIVIDEND (0x80000000).
- Sub-module div_special_case (combinational): takes op, a and b; outputs is_special and special_result. It is instantiated once at the accept point.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2; divider returns quot 0xFFFFFFFD -> one div_v_o/div_ready_i handshake; cdb_data_o=0xFFFFFFFD with the issued tag; div_yumi_o pulses exactly once.
- REMU a=0x1234, b=0 -> no div_v_o ever; cdb_req_o high the cycle after accept; cdb_data_o=0x1234. DIVU a=5, b=0 -> 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. No divider launch in either case.
- Flush in S_WAIT, divider v_o 20 cycles later -> div_yumi_o asserted on that cycle; cdb_req_o never asserted; issue_ready_o returns next cycle.
- cdb_gnt_i held low for 5 cycles in S_BCAST -> cdb_req_o, cdb_tag_o and cdb_data_o stable for 5 cycles; issue_ready_o=0; IDLE one cycle after the grant.
- reset_i driven low mid-S_WAIT (asynchronous, between clock edges) -> outputs reach reset values immediately; after release issue_ready_o=1 and a fresh DIVU 100/7 yields 14.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divide functional unit front end.
// Holds the op encoding, controller states and special-case results.
package div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DRAIN  = 3'd3,
        S_BCAST  = 3'd4
    } div_fu_state_e;

    localparam logic [DIV_W-1:0] DIV_ZERO_QUOT    = '1;
    localparam logic [DIV_W-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Detects divide-by-zero and signed overflow for RV32M divide ops.
// Produces the architectural result so the divider need not run.
module div_special_case
    import div_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  div_op_e                 i_op,
    input  logic [data_width_p-1:0] i_a,
    input  logic [data_width_p-1:0] i_b,
    output logic                    o_is_special,
    output logic [data_width_p-1:0] o_result
);

    logic w_zero;
    logic w_ovf;
    logic w_rem;

    assign w_zero = (i_b == '0);
    assign w_ovf  = op_is_signed(i_op)
                  && (i_a == DIV_OVF_DIVIDEND)
                  && (i_b == '1);
    assign w_rem  = op_is_rem(i_op);

    assign o_is_special = w_zero | w_ovf;

    always_comb begin
        o_result = '0;
        unique case (1'b1)
            w_zero & ~w_rem: o_result = DIV_ZERO_QUOT;
            w_zero &  w_rem: o_result = i_a;
            w_ovf  & ~w_rem: o_result = DIV_OVF_DIVIDEND;
            default:         o_result = '0;
        endcase
    end

endmodule

// File: rtl/div_fu_ctrl.sv
// Divide FU controller: issue, special-case bypass, nrd_div handshake,
// flush draining and CDB broadcast for one in-flight RV32M divide op.
module div_fu_ctrl
    import div_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int tag_width_p  = 6
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    issue_v_i,
    output logic                    issue_ready_o,
    input  logic [1:0]              issue_op_i,
    input  logic [data_width_p-1:0] issue_a_i,
    input  logic [data_width_p-1:0] issue_b_i,
    input  logic [tag_width_p-1:0]  issue_tag_i,
    input  logic                    flush_i,
    output logic                    div_v_o,
    input  logic                    div_ready_i,
    output logic                    div_signed_o,
    output logic [data_width_p-1:0] div_a_o,
    output logic [data_width_p-1:0] div_b_o,
    input  logic                    div_v_i,
    input  logic [data_width_p-1:0] div_quot_i,
    input  logic [data_width_p-1:0] div_rem_i,
    output logic                    div_yumi_o,
    output logic                    cdb_req_o,
    input  logic                    cdb_gnt_i,
    output logic [tag_width_p-1:0]  cdb_tag_o,
    output logic [data_width_p-1:0] cdb_data_o
);

    div_fu_state_e             r_state;
    div_fu_state_e             w_state_n;
    div_op_e                   r_op;
    logic [data_width_p-1:0]   r_a;
    logic [data_width_p-1:0]   r_b;
    logic [tag_width_p-1:0]    r_tag;
    logic [data_width_p-1:0]   r_result;

    div_op_e                   w_issue_op;
    logic                      w_accept;
    logic                      w_special;
    logic [data_width_p-1:0]   w_special_res;
    logic                      w_capture;

    assign w_issue_op = div_op_e'(issue_op_i);

    div_special_case #(
        .data_width_p(data_width_p)
    ) u_special (
        .i_op         (w_issue_op),
        .i_a          (issue_a_i),
        .i_b          (issue_b_i),
        .o_is_special (w_special),
        .o_result     (w_special_res)
    );

    assign issue_ready_o = (r_state == S_IDLE) & ~flush_i;
    assign w_accept      = issue_v_i & issue_ready_o;

    assign div_v_o      = (r_state == S_LAUNCH) & ~flush_i;
    assign div_signed_o = op_is_signed(r_op);
    assign div_a_o      = r_a;
    assign div_b_o      = r_b;

    // A flush in S_WAIT leaves the result pending; S_DRAIN consumes it.
    assign w_capture  = (r_state == S_WAIT) & div_v_i & ~flush_i;
    assign div_yumi_o = w_capture
                      | ((r_state == S_DRAIN) & div_v_i);

    assign cdb_req_o  = (r_state == S_BCAST) & ~flush_i;
    assign cdb_tag_o  = r_tag;
    assign cdb_data_o = r_result;

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n = w_special ? S_BCAST : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (flush_i) begin
                    w_state_n = S_IDLE;
                end else if (div_ready_i) begin
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    w_state_n = S_DRAIN;
                end else if (div_v_i) begin
                    w_state_n = S_BCAST;
                end
            end
            S_DRAIN: begin
                if (div_v_i) begin
                    w_state_n = S_IDLE;
                end
            end
            S_BCAST: begin
                if (flush_i || cdb_gnt_i) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= S_IDLE;
            r_op     <= DIV;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_op  <= w_issue_op;
                r_a   <= issue_a_i;
                r_b   <= issue_b_i;
                r_tag <= issue_tag_i;
                if (w_special) begin
                    r_result <= w_special_res;
                end
            end
            if (w_capture) begin
                r_result <= op_is_rem(r_op) ? div_rem_i : div_quot_i;
            end
        end
    end

endmodule

// File: tb/tb_div_fu_ctrl.sv
// Self-checking bench for div_fu_ctrl; the bench plays nrd_div and the CDB.
// Expected results come from RV32M arithmetic rules computed here.
module tb_div_fu_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_v_i;
    logic        issue_ready_o;
    logic [1:0]  issue_op_i;
    logic [31:0] issue_a_i;
    logic [31:0] issue_b_i;
    logic [5:0]  issue_tag_i;
    logic        flush_i;
    logic        div_v_o;
    logic        div_ready_i;
    logic        div_signed_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        div_v_i;
    logic [31:0] div_quot_i;
    logic [31:0] div_rem_i;
    logic        div_yumi_o;
    logic        cdb_req_o;
    logic        cdb_gnt_i;
    logic [5:0]  cdb_tag_o;
    logic [31:0] cdb_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    div_fu_ctrl #(.data_width_p(32), .tag_width_p(6)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .issue_v_i     (issue_v_i),
        .issue_ready_o (issue_ready_o),
        .issue_op_i    (issue_op_i),
        .issue_a_i     (issue_a_i),
        .issue_b_i     (issue_b_i),
        .issue_tag_i   (issue_tag_i),
        .flush_i       (flush_i),
        .div_v_o       (div_v_o),
        .div_ready_i   (div_ready_i),
        .div_signed_o  (div_signed_o),
        .div_a_o       (div_a_o),
        .div_b_o       (div_b_o),
        .div_v_i       (div_v_i),
        .div_quot_i    (div_quot_i),
        .div_rem_i     (div_rem_i),
        .div_yumi_o    (div_yumi_o),
        .cdb_req_o     (cdb_req_o),
        .cdb_gnt_i     (cdb_gnt_i),
        .cdb_tag_o     (cdb_tag_o),
        .cdb_data_o    (cdb_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_ovf(input logic [1:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic ref_special(input logic [1:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || is_ovf(op, a, b);
    endfunction

    // RV32M result: op[1] selects remainder, op[0]=0 means signed.
    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (is_ovf(op, a, b)) return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) begin
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag,
                         input int rdy_dly, input int lat, input int gnt_dly);
        logic [31:0] exp;
        logic        spec;
        exp  = ref_res(op, a, b);
        spec = ref_special(op, a, b);
        issue_v_i   = 1'b1;
        issue_op_i  = op;
        issue_a_i   = a;
        issue_b_i   = b;
        issue_tag_i = tag;
        #1;
        chk("issue_ready_idle", 32'(issue_ready_o), 1);
        chk("div_v_at_accept", 32'(div_v_o), 0);
        tick();
        issue_v_i = 1'b0;
        issue_a_i = $urandom;
        issue_b_i = $urandom;
        if (!spec) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                div_ready_i = (i == rdy_dly);
                #1;
                chk("launch_div_v", 32'(div_v_o), 1);
                chk("launch_div_a", div_a_o, a);
                chk("launch_div_b", div_b_o, b);
                chk("launch_signed", 32'(div_signed_o), 32'(!op[0]));
                chk("launch_no_req", 32'(cdb_req_o), 0);
                chk("launch_not_ready", 32'(issue_ready_o), 0);
                tick();
            end
            div_ready_i = 1'b0;
            for (int i = 0; i <= lat; i++) begin
                div_v_i    = (i == lat);
                div_quot_i = ref_res({1'b0, op[0]}, a, b);
                div_rem_i  = ref_res({1'b1, op[0]}, a, b);
                #1;
                chk("wait_div_v_low", 32'(div_v_o), 0);
                chk("wait_yumi", 32'(div_yumi_o), 32'(i == lat));
                chk("wait_no_req", 32'(cdb_req_o), 0);
                tick();
            end
            div_v_i    = 1'b0;
            div_quot_i = $urandom;
            div_rem_i  = $urandom;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            cdb_gnt_i = (i == gnt_dly);
            #1;
            chk("bcast_req", 32'(cdb_req_o), 1);
            chk("bcast_tag", 32'(cdb_tag_o), 32'(tag));
            chk("bcast_data", cdb_data_o, exp);
            chk("bcast_not_ready", 32'(issue_ready_o), 0);
            chk("bcast_no_div_v", 32'(div_v_o), 0);
            chk("bcast_no_yumi", 32'(div_yumi_o), 0);
            tick();
        end
        cdb_gnt_i = 1'b0;
        #1;
        chk("post_gnt_ready", 32'(issue_ready_o), 1);
        chk("post_gnt_no_req", 32'(cdb_req_o), 0);
    endtask

    task automatic to_wait(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [5:0] tag);
        issue_v_i   = 1'b1;
        issue_op_i  = op;
        issue_a_i   = a;
        issue_b_i   = b;
        issue_tag_i = tag;
        tick();
        issue_v_i   = 1'b0;
        div_ready_i = 1'b1;
        #1;
        chk("to_wait_div_v", 32'(div_v_o), 1);
        tick();
        div_ready_i = 1'b0;
        #1;
        chk("in_wait_div_v_low", 32'(div_v_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset_i     = 1'b0;
        issue_v_i   = 1'b0;
        issue_op_i  = 2'd0;
        issue_a_i   = '0;
        issue_b_i   = '0;
        issue_tag_i = '0;
        flush_i     = 1'b0;
        div_ready_i = 1'b0;
        div_v_i     = 1'b0;
        div_quot_i  = '0;
        div_rem_i   = '0;
        cdb_gnt_i   = 1'b0;
        #2;
        chk("rst_issue_ready", 32'(issue_ready_o), 1);
        chk("rst_div_v", 32'(div_v_o), 0);
        chk("rst_yumi", 32'(div_yumi_o), 0);
        chk("rst_req", 32'(cdb_req_o), 0);
        chk("rst_tag", 32'(cdb_tag_o), 0);
        chk("rst_data", cdb_data_o, 0);
        #21;
        reset_i = 1'b1;
        tick();

        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 6'h15, 1, 3, 0);
        do_op(2'd3, 32'h0000_1234, 32'd0, 6'h2A, 0, 0, 0);
        do_op(2'd1, 32'd5, 32'd0, 6'h01, 0, 0, 1);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 6'h3F, 0, 0, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'h20, 0, 0, 0);
        do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'h11, 0, 1, 0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 6'h07, 2, 0, 5);

        flush_i   = 1'b1;
        issue_v_i = 1'b1;
        #1;
        chk("flush_idle_not_ready", 32'(issue_ready_o), 0);
        tick();
        flush_i   = 1'b0;
        issue_v_i = 1'b0;
        #1;
        chk("flush_idle_no_accept", 32'(issue_ready_o), 1);
        chk("flush_idle_no_div_v", 32'(div_v_o), 0);
        chk("flush_idle_no_req", 32'(cdb_req_o), 0);

        issue_v_i   = 1'b1;
        issue_op_i  = 2'd1;
        issue_a_i   = 32'd50;
        issue_b_i   = 32'd3;
        tick();
        issue_v_i = 1'b0;
        flush_i   = 1'b1;
        #1;
        chk("flush_launch_div_v", 32'(div_v_o), 0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_launch_idle", 32'(issue_ready_o), 1);
        chk("flush_launch_div_v_after", 32'(div_v_o), 0);

        to_wait(2'd0, 32'd1000, 32'd7, 6'h0C);
        tick();
        tick();
        flush_i = 1'b1;
        #1;
        chk("flush_wait_no_yumi", 32'(div_yumi_o), 0);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("drain_no_yumi", 32'(div_yumi_o), 0);
            chk("drain_no_req", 32'(cdb_req_o), 0);
            chk("drain_not_ready", 32'(issue_ready_o), 0);
            tick();
        end
        div_v_i    = 1'b1;
        div_quot_i = 32'd142;
        div_rem_i  = 32'd6;
        #1;
        chk("drain_yumi", 32'(div_yumi_o), 1);
        chk("drain_yumi_no_req", 32'(cdb_req_o), 0);
        tick();
        div_v_i = 1'b0;
        #1;
        chk("drain_done_ready", 32'(issue_ready_o), 1);
        chk("drain_done_no_req", 32'(cdb_req_o), 0);

        issue_v_i   = 1'b1;
        issue_op_i  = 2'd0;
        issue_a_i   = 32'd9;
        issue_b_i   = 32'd0;
        issue_tag_i = 6'h33;
        tick();
        issue_v_i = 1'b0;
        #1;
        chk("flush_bcast_req_before", 32'(cdb_req_o), 1);
        flush_i   = 1'b1;
        cdb_gnt_i = 1'b1;
        #1;
        chk("flush_bcast_req", 32'(cdb_req_o), 0);
        tick();
        flush_i   = 1'b0;
        cdb_gnt_i = 1'b0;
        #1;
        chk("flush_bcast_idle", 32'(issue_ready_o), 1);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(op, a, b, 6'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        end

        to_wait(2'd0, 32'd77, 32'd5, 6'h2E);
        tick();
        #3;
        reset_i = 1'b0;
        #1;
        chk("amid_rst_ready", 32'(issue_ready_o), 1);
        chk("amid_rst_div_v", 32'(div_v_o), 0);
        chk("amid_rst_yumi", 32'(div_yumi_o), 0);
        chk("amid_rst_req", 32'(cdb_req_o), 0);
        chk("amid_rst_tag", 32'(cdb_tag_o), 0);
        chk("amid_rst_data", cdb_data_o, 0);
        #2;
        reset_i = 1'b1;
        tick();
        chk("post_rst_ready", 32'(issue_ready_o), 1);
        do_op(2'd1, 32'd100, 32'd7, 6'h19, 0, 2, 0);
        chk("divu_100_7", cdb_data_o, 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
